fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage; produces the 32-bit instruction word and its PC for the decode stage.
- Owns the fetch PC and issues in-order requests to the instruction memory port.
- Buffers returned words in a small FIFO.
- Handles redirects from execute (branch/jump/JALR target) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded at reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, >= 2. Also caps in-flight requests plus buffered words.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  64  fetch address, word aligned.
- imem_rsp_valid_i  in  1  response valid; responses return in request order.
- imem_rsp_data_i  in  32  instruction word.
- redirect_valid_i  in  1  PC redirect from execute.
- redirect_pc_i  in  64  redirect target.
- instr_valid_o  out  1  instruction available to decode.
- instr_ready_i  in  1  decode accepts; low = stall.
- instr_o  out  32  instruction word, drives decode instr_i.
- instr_pc_o  out  64  PC of instr_o.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_ni).
- Reset state: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
  - Outputs during reset: imem_req_valid_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, imem_req_addr_o=RESET_PC.
- Request issue:
  - imem_req_valid_o = !redirect_valid_i && (outstanding + fifo_count < FIFO_DEPTH) && !stopped.
  - The credit check counts in-flight responses that will be dropped.
  - imem_req_addr_o = fetch_pc.
  - A transfer occurs only on valid&&ready. Valid may drop, and the address may change, before ready; the memory samples only on the handshake.
- On request handshake: fetch_pc += 4 (64-bit wrap); outstanding += 1. Each request's PC is recorded in a PC queue of FIFO_DEPTH entries.
- Response arrival: outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
  - Otherwise push {data, queued PC} into the FIFO.
  - Push and pop in the same cycle are allowed when the FIFO is full.
  - Overflow cannot occur because of the credit rule.
  - A response with outstanding==0 is a protocol violation: ignored, counters unchanged.
- Output:
  - instr_valid_o = FIFO not empty; instr_o/instr_pc_o = FIFO head.
  - Pop on instr_valid_o && instr_ready_i.
  - Head is stable while stalled.
- Latency: a response in cycle N is visible on instr_o in cycle N+1. There is no bypass.
- Redirect (redirect_valid_i=1 at edge):
  - fetch_pc <= {redirect_pc_i[63:2], 2'b00}.
  - FIFO and PC queue are flushed; any simultaneous pop is cancelled.
  - drop_cnt <= outstanding minus 1 if a response arrives that same cycle, else outstanding.
  - Clears stopped.
  - No request is issued in the redirect cycle. The first request at the new PC is eligible the following cycle.
- Back-to-back redirects: last one wins; drop_cnt is recomputed each time from total outstanding.
- Redirect with an empty pipe: drop_cnt=0, and the fetch at the target starts the next cycle.
- Reset mid-operation: all state returns to reset values immediately. Responses to pre-reset requests must not be returned by memory (memory is reset together with this block).

Optional Feature:
- Macro: FETCH_ACCESS_FAULT_EN.
- Enabled:
  - Adds ports imem_rsp_err_i (in, 1) and instr_err_o (out, 1).
  - Error flag is stored per FIFO entry.
  - A non-dropped error response sets stopped: no further requests until redirect.
  - instr_err_o is high with the faulting entry at the FIFO head; instr_o=32'h0000_0013 (NOP) for that entry.
- Disabled: ports absent; all responses are treated as good; stopped is never set.

Test Plan:
- Reset release, memory always ready with 1-cycle response: requests at 0x8000_0000, 0x8000_0004, 0x8000_0008…; instr_pc_o follows in order; first instr_valid_o appears 2 cycles after the first handshake.
- instr_ready_i=0 for 10 cycles: FIFO fills to 2, imem_req_valid_o drops, instr_o/instr_pc_o hold 0x8000_0000; on release, one instruction per cycle with no PC gap.
- Two requests in flight, redirect to 0x8000_0100: both stale responses are discarded; the next instr_pc_o is 0x8000_0100.
- Redirect in the same cycle as a response and a pop: the response is dropped, drop_cnt = outstanding-1, the FIFO is empty next cycle, and no word is popped twice.
- redirect_pc_i=0x8000_0106: fetch address is 0x8000_0104; fetch_pc wrap from 0xFFFF_FFFF_FFFF_FFFC advances to 0x0.
- FETCH_ACCESS_FAULT_EN: error on the 2nd response gives instr_err_o=1, instr_o=0x13 at PC+4; no further requests until redirect, after which fetch resumes.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, in-order imem requests, instruction buffer, redirect flush
// Optional feature macro: FETCH_ACCESS_FAULT_EN (per-entry access-fault flag, fetch stops until redirect)
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
`ifdef FETCH_ACCESS_FAULT_EN
  input  logic        imem_rsp_err_i,
  output logic        instr_err_o,
`endif
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d;
  logic [PW-1:0] pcq_rd_q, pcq_rd_d;
  logic          stopped_q, stopped_d;

  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [63:0] fifo_pc_q   [FIFO_DEPTH];
  logic        fifo_err_q  [FIFO_DEPTH];
  logic [63:0] pcq_q       [FIFO_DEPTH];

  logic        rsp_err;
  logic        req_fire, rsp_fire, rsp_drop, push, pop;
  logic        credit_ok, head_err;
  logic [CW:0] inflight;
  logic [1:0]  unused_redirect_lsb;

`ifdef FETCH_ACCESS_FAULT_EN
  assign rsp_err = imem_rsp_err_i;
`else
  assign rsp_err = 1'b0;
`endif

  assign unused_redirect_lsb = redirect_pc_i[1:0];

  // Credits cover every in-flight request (including ones that will be dropped) plus buffered words
  assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = inflight < DEPTH_W;

  assign imem_req_valid_o = rst_ni && !redirect_valid_i && credit_ok && !stopped_q;
  assign imem_req_addr_o  = fetch_pc_q;

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  // A response with nothing outstanding is a protocol violation and is ignored entirely
  assign rsp_fire = imem_rsp_valid_i && (outstanding_q != '0);
  assign rsp_drop = rsp_fire && (drop_cnt_q != '0);
  assign push     = rsp_fire && !rsp_drop && !redirect_valid_i;
  assign pop      = instr_valid_o && instr_ready_i && !redirect_valid_i;

  assign instr_valid_o = (fifo_cnt_q != '0);
  assign head_err      = fifo_err_q[fifo_rd_q];
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[fifo_rd_q] : 64'h0;
  assign instr_o       = !instr_valid_o ? 32'h0 :
                         (head_err ? NOP_INSTR : fifo_data_q[fifo_rd_q]);
`ifdef FETCH_ACCESS_FAULT_EN
  assign instr_err_o   = instr_valid_o && head_err;
`endif

  // Next-state for PC, counters, pointers and the stop flag; redirect overrides flow updates
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    stopped_d     = stopped_q;
    if (redirect_valid_i) begin
      fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
      drop_cnt_d = outstanding_q - CW'(rsp_fire);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
      stopped_d  = 1'b0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
        pcq_wr_d   = pcq_wr_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        fifo_wr_d = fifo_wr_q + PW'(1);
        pcq_rd_d  = pcq_rd_q + PW'(1);
        if (rsp_err) begin
          stopped_d = 1'b1;
        end
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + PW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      stopped_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      stopped_q     <= stopped_d;
    end
  end

  // Payload storage: request PCs on handshake, {data, PC, err} on accepted response
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      pcq_q[pcq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      fifo_data_q[fifo_wr_q] <= imem_rsp_data_i;
      fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
      fifo_err_q[fifo_wr_q]  <= rsp_err;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (table vectors plus redirect/wrap/fault sequences)
module tb_fetch_unit;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
`ifdef FETCH_ACCESS_FAULT_EN
  logic        imem_rsp_err_i;
  logic        instr_err_o;
`endif
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model: fixed latency 1..3, ordered responses
  int          mem_lat;
  logic        pv [3];
  logic [63:0] pa [3];
  logic [63:0] err_addr;

  typedef struct {
    logic        rdy;
    logic        exp_rv;
    logic [63:0] exp_ra;
    logic        exp_iv;
    logic [63:0] exp_ipc;
  } vec_t;
  vec_t tbl [17];

  fetch_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
`ifdef FETCH_ACCESS_FAULT_EN
    .imem_rsp_err_i   (imem_rsp_err_i),
    .instr_err_o      (instr_err_o),
`endif
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pa[i] = 64'h0;
    end
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
`ifdef FETCH_ACCESS_FAULT_EN
    imem_rsp_err_i   = 1'b0;
`endif
  endtask

  // Called at the negedge: samples the handshake, crosses the posedge, presents responses
  task automatic adv();
    logic        hs;
    logic [63:0] a;
    hs = imem_req_valid_o && imem_req_ready_i;
    a  = imem_req_addr_o;
    @(posedge clk);
    #1;
    pv[2] = pv[1]; pa[2] = pa[1];
    pv[1] = pv[0]; pa[1] = pa[0];
    pv[0] = hs;    pa[0] = a;
    imem_rsp_valid_i = pv[mem_lat-1];
    imem_rsp_data_i  = pv[mem_lat-1] ? mdata(pa[mem_lat-1]) : 32'h0;
`ifdef FETCH_ACCESS_FAULT_EN
    imem_rsp_err_i   = pv[mem_lat-1] && (pa[mem_lat-1] == err_addr);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    mem_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Bounded wait for the next valid instruction, check it, then advance one cycle
  task automatic wait_iv(input string nm, input logic [63:0] pc, input logic err);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid_o && n < 20) begin
      adv();
      @(negedge clk);
      n++;
    end
    if (!instr_valid_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no instr_valid_o expected pc %h", nm, pc);
    end else begin
      chk({nm, "_pc"}, instr_pc_o, pc);
      chk({nm, "_data"}, {32'h0, instr_o}, {32'h0, err ? 32'h0000_0013 : mdata(pc)});
`ifdef FETCH_ACCESS_FAULT_EN
      chk({nm, "_err"}, {63'h0, instr_err_o}, {63'h0, err});
`endif
    end
    adv();
  endtask

  initial begin
    // Stall scenario, latency-1 memory, decode stalled for the first 10 cycles
    tbl[0]  = '{1'b0, 1'b1, B + 64'h00, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 1'b1, B + 64'h04, 1'b0, 64'h0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 1'b0, B + 64'h08, 1'b1, B};
    tbl[10] = '{1'b1, 1'b0, B + 64'h08, 1'b1, B + 64'h00};
    tbl[11] = '{1'b1, 1'b1, B + 64'h08, 1'b1, B + 64'h04};
    tbl[12] = '{1'b1, 1'b1, B + 64'h0C, 1'b0, 64'h0};
    tbl[13] = '{1'b1, 1'b0, B + 64'h10, 1'b1, B + 64'h08};
    tbl[14] = '{1'b1, 1'b1, B + 64'h10, 1'b1, B + 64'h0C};
    tbl[15] = '{1'b1, 1'b1, B + 64'h14, 1'b0, 64'h0};
    tbl[16] = '{1'b1, 1'b0, B + 64'h18, 1'b1, B + 64'h10};

    rst_n            = 1'b0;
    imem_req_ready_i = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 64'h0;
    instr_ready_i    = 1'b0;
    mem_lat          = 1;
    err_addr         = 64'h0;
    mem_clear();

    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid_o}, 64'h0);
    chk("rst_instr", {32'h0, instr_o}, 64'h0);
    chk("rst_instr_pc", instr_pc_o, 64'h0);
    chk("rst_req_addr", imem_req_addr_o, B);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      instr_ready_i = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_valid", i), {63'h0, imem_req_valid_o}, {63'h0, tbl[i].exp_rv});
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr_o, tbl[i].exp_ra);
      chk($sformatf("tbl%0d_instr_valid", i), {63'h0, instr_valid_o}, {63'h0, tbl[i].exp_iv});
      chk($sformatf("tbl%0d_instr_pc", i), instr_pc_o, tbl[i].exp_ipc);
      chk($sformatf("tbl%0d_instr", i), {32'h0, instr_o},
          {32'h0, tbl[i].exp_iv ? mdata(tbl[i].exp_ipc) : 32'h0});
      adv();
    end

    // Asynchronous reset while an instruction is buffered
    @(negedge clk);
    chk("pre_reset_instr_valid", {63'h0, instr_valid_o}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_instr_valid", {63'h0, instr_valid_o}, 64'h0);
    chk("mid_reset_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    chk("mid_reset_req_addr", imem_req_addr_o, B);

    // Two requests in flight, redirect discards both stale responses
    mem_lat = 3;
    do_reset();
    instr_ready_i = 1'b1;
    @(negedge clk); adv();
    @(negedge clk);
    chk("two_fl_c1_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    adv();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = B + 64'h100;
    @(negedge clk);
    chk("two_fl_redir_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    adv();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("two_fl_c3_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    chk("two_fl_c3_req_addr", imem_req_addr_o, B + 64'h100);
    adv();
    @(negedge clk);
    chk("two_fl_c4_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    adv();
    wait_iv("two_fl_first", B + 64'h100, 1'b0);

    // Redirect coinciding with a response and a pop
    mem_lat = 2;
    do_reset();
    repeat (3) begin
      @(negedge clk); adv();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = B + 64'h200;
    @(negedge clk);
    chk("rsp_pop_redir_rsp", {63'h0, imem_rsp_valid_i}, 64'h1);
    chk("rsp_pop_redir_iv", {63'h0, instr_valid_o}, 64'h1);
    chk("rsp_pop_redir_pc", instr_pc_o, B);
    adv();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("rsp_pop_next_iv", {63'h0, instr_valid_o}, 64'h0);
    chk("rsp_pop_next_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("rsp_pop_next_req_addr", imem_req_addr_o, B + 64'h200);
    adv();
    wait_iv("rsp_pop_first", B + 64'h200, 1'b0);

    // Redirect with a response arriving and another still outstanding; unaligned target
    do_reset();
    repeat (2) begin
      @(negedge clk); adv();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = B + 64'h106;
    @(negedge clk);
    chk("drop_m1_redir_rsp", {63'h0, imem_rsp_valid_i}, 64'h1);
    adv();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("drop_m1_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("drop_m1_req_addr", imem_req_addr_o, B + 64'h104);
    adv();
    wait_iv("drop_m1_first", B + 64'h104, 1'b0);

    // Empty-pipe redirect to the top of the address space, then 64-bit wrap
    mem_lat = 1;
    do_reset();
    imem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    chk("wrap_redir_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    adv();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    @(negedge clk);
    chk("wrap_c1_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("wrap_c1_req_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    adv();
    @(negedge clk);
    chk("wrap_c2_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("wrap_c2_req_addr", imem_req_addr_o, 64'h0);
    adv();
    wait_iv("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    wait_iv("wrap_zero", 64'h0, 1'b0);

`ifdef FETCH_ACCESS_FAULT_EN
    // Access fault on the second response stops fetch until a redirect
    err_addr = B + 64'h04;
    do_reset();
    wait_iv("fault_first", B, 1'b0);
    wait_iv("fault_second", B + 64'h04, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("fault_stop%0d_req_valid", i), {63'h0, imem_req_valid_o}, 64'h0);
      adv();
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = B + 64'h300;
    @(negedge clk); adv();
    redirect_valid_i = 1'b0;
    @(negedge clk);
    chk("fault_resume_req_valid", {63'h0, imem_req_valid_o}, 64'h1);
    chk("fault_resume_req_addr", imem_req_addr_o, B + 64'h300);
    adv();
    wait_iv("fault_resume", B + 64'h300, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
